// File: rtl/act_lut_arbiter.sv
// Arbiter sharing one activation LUT between the reg_holder path (requester 0)
// and the GSRAM path (requester 1). Round-robin grant with optional burst lock;
// the LUT read pipeline is tracked so each result returns to its issuer with its tag.
module act_lut_arbiter #(
  parameter int unsigned AW      = 8,
  parameter int unsigned DW      = 16,
  parameter int unsigned TW      = 4,
  parameter int unsigned LUT_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [TW-1:0] tag0,
  input  logic [TW-1:0] tag1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          lut_en,
  output logic [AW-1:0] lut_addr,
  output logic          LUT_mux,
  input  logic [DW-1:0] lut_dout,
  output logic          rsp_valid0,
  output logic          rsp_valid1,
  output logic [DW-1:0] rsp_data,
  output logic [TW-1:0] rsp_tag,
  output logic [1:0]    inflight,
  input  logic          stat_clr,
  output logic [15:0]   gcnt0,
  output logic [15:0]   gcnt1
);

  if (LUT_LAT < 1 || LUT_LAT > 3) begin : g_bad_lat
    $error("act_lut_arbiter: LUT_LAT must be 1..3");
  end

  // Marks the output stage, whose entry retires this cycle and is no longer in flight.
  localparam logic [LUT_LAT-1:0] LastStage = LUT_LAT'(1) << (LUT_LAT - 1);

  logic                      rr_q;        // 0: requester 0 has priority
  logic                      lock_vld_q;
  logic                      lock_id_q;
  logic                      xfer;
  logic                      xfer_src;
  logic                      xfer_lock;
  logic [TW-1:0]             xfer_tag;
  logic [LUT_LAT-1:0]        vld_d,  vld_q;
  logic [LUT_LAT-1:0]        src_d,  src_q;
  logic [LUT_LAT-1:0][TW-1:0] tag_d, tag_q;
  logic                      rsp_vld;
  logic [15:0]               gcnt0_q, gcnt1_q;

  // Grant selection: lock owner first, then a lone requester, then round-robin.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_vld_q && !lock_id_q && req0) begin
      gnt0 = 1'b1;
    end else if (lock_vld_q && lock_id_q && req1) begin
      gnt1 = 1'b1;
    end else if (req0 && !req1) begin
      gnt0 = 1'b1;
    end else if (req1 && !req0) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = ~rr_q;
      gnt1 = rr_q;
    end
  end

  // LUT-side mux of the granted request; idle drives zeros.
  always_comb begin
    xfer      = gnt0 | gnt1;
    xfer_src  = gnt1;
    lut_en    = xfer;
    LUT_mux   = gnt1;
    lut_addr  = '0;
    xfer_tag  = '0;
    xfer_lock = 1'b0;
    if (gnt1) begin
      lut_addr  = addr1;
      xfer_tag  = tag1;
      xfer_lock = lock1;
    end else if (gnt0) begin
      lut_addr  = addr0;
      xfer_tag  = tag0;
      xfer_lock = lock0;
    end
  end

  // Round-robin pointer and lock owner; lock drops on any cycle without a transfer
  // because an owner still requesting would have been granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q       <= 1'b0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= 1'b0;
    end else if (xfer) begin
      rr_q       <= ~xfer_src;
      lock_vld_q <= xfer_lock;
      lock_id_q  <= xfer_src;
    end else begin
      lock_vld_q <= 1'b0;
    end
  end

  // Response pipeline next state: stage 0 takes the new transfer, others shift.
  assign vld_d[0] = xfer;
  assign src_d[0] = xfer_src;
  assign tag_d[0] = xfer_tag;
  for (genvar g = 1; g < LUT_LAT; g++) begin : g_shift
    assign vld_d[g] = vld_q[g-1];
    assign src_d[g] = src_q[g-1];
    assign tag_d[g] = tag_q[g-1];
  end

  // Response pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      src_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      src_q <= src_d;
      tag_q <= tag_d;
    end
  end

  // The last stage lines up with the LUT output cycle, so lut_dout is forwarded there.
  always_comb begin
    rsp_vld    = vld_q[LUT_LAT-1];
    rsp_valid0 = rsp_vld & ~src_q[LUT_LAT-1];
    rsp_valid1 = rsp_vld &  src_q[LUT_LAT-1];
    rsp_data   = rsp_vld ? lut_dout : '0;
    rsp_tag    = rsp_vld ? tag_q[LUT_LAT-1] : '0;
  end

  assign inflight = 2'($countones(vld_q & ~LastStage)) + 2'(xfer);

  // Saturating grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || stat_clr) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
    end else begin
      if (gnt0 && gcnt0_q != 16'hFFFF) gcnt0_q <= gcnt0_q + 16'd1;
      if (gnt1 && gcnt1_q != 16'hFFFF) gcnt1_q <= gcnt1_q + 16'd1;
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;

endmodule

// File: tb/tb_act_lut_arbiter.sv
// Bench for act_lut_arbiter: two instances (LUT_LAT=1 and 3) share one stimulus
// stream; a spec-level model predicts grants and counters, a scoreboard queue per
// instance holds expected responses which the monitors pop and compare.
module tb_act_lut_arbiter;
  localparam int AW = 8, DW = 16, TW = 4;

  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, stat_clr = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [TW-1:0] tag0 = '0, tag1 = '0;

  logic          gnt0_a, gnt1_a, en_a, mux_a, rv0_a, rv1_a;
  logic [AW-1:0] la_a;
  logic [DW-1:0] dout_a, rdata_a;
  logic [TW-1:0] rtag_a;
  logic [1:0]    infl_a;
  logic [15:0]   gc0_a, gc1_a;
  logic          gnt0_b, gnt1_b, en_b, mux_b, rv0_b, rv1_b;
  logic [AW-1:0] la_b;
  logic [DW-1:0] dout_b, rdata_b;
  logic [TW-1:0] rtag_b;
  logic [1:0]    infl_b;
  logic [15:0]   gc0_b, gc1_b;

  always #5 clk = ~clk;

  act_lut_arbiter #(.AW(AW), .DW(DW), .TW(TW), .LUT_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .tag0(tag0), .tag1(tag1), .lock0(lock0), .lock1(lock1), .gnt0(gnt0_a), .gnt1(gnt1_a),
    .lut_en(en_a), .lut_addr(la_a), .LUT_mux(mux_a), .lut_dout(dout_a),
    .rsp_valid0(rv0_a), .rsp_valid1(rv1_a), .rsp_data(rdata_a), .rsp_tag(rtag_a),
    .inflight(infl_a), .stat_clr(stat_clr), .gcnt0(gc0_a), .gcnt1(gc1_a));

  act_lut_arbiter #(.AW(AW), .DW(DW), .TW(TW), .LUT_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .tag0(tag0), .tag1(tag1), .lock0(lock0), .lock1(lock1), .gnt0(gnt0_b), .gnt1(gnt1_b),
    .lut_en(en_b), .lut_addr(la_b), .LUT_mux(mux_b), .lut_dout(dout_b),
    .rsp_valid0(rv0_b), .rsp_valid1(rv1_b), .rsp_data(rdata_b), .rsp_tag(rtag_b),
    .inflight(infl_b), .stat_clr(stat_clr), .gcnt0(gc0_b), .gcnt1(gc1_b));

  // LUT models: content is addr + 0x100, output LUT_LAT clocks after the read.
  logic [DW-1:0] lut1_q, lut3_q [3];
  always @(posedge clk) begin
    lut1_q    <= 16'(la_a) + 16'h100;
    lut3_q[0] <= 16'(la_b) + 16'h100;
    lut3_q[1] <= lut3_q[0];
    lut3_q[2] <= lut3_q[1];
  end
  assign dout_a = lut1_q;
  assign dout_b = lut3_q[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {int src; int tag; int data; int issue;} exp_t;
  exp_t q1[$], q3[$];

  // Reference model state.
  int rr_m = 0, owner_m = -1, hist = 0;
  int gcnt_m [2] = '{0, 0};

  function automatic int model_grant();
    if (owner_m == 0 && req0) return 0;
    if (owner_m == 1 && req1) return 1;
    if (req0 && req1) return rr_m;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  // One clock: check combinational/registered outputs mid-cycle, advance the model.
  task automatic step(output int g);
    exp_t e;
    int   ea;
    @(negedge clk);
    g = -1;
    if (reset) begin
      rr_m = 0; owner_m = -1; hist = 0; gcnt_m = '{0, 0};
    end else begin
      g  = model_grant();
      ea = (g == 0) ? int'(addr0) : (g == 1) ? int'(addr1) : 0;
      chk("gnt0_l1", gnt0_a, int'(g == 0));  chk("gnt1_l1", gnt1_a, int'(g == 1));
      chk("gnt0_l3", gnt0_b, int'(g == 0));  chk("gnt1_l3", gnt1_b, int'(g == 1));
      chk("lut_en", en_a, int'(g >= 0));     chk("lut_addr", la_a, ea);
      chk("lut_mux", mux_a, int'(g == 1));   chk("lut_addr_l3", la_b, ea);
      hist = ((hist << 1) | int'(g >= 0)) & 7;
      chk("inflight_l1", infl_a, hist & 1);
      chk("inflight_l3", infl_b, $countones(hist));
      chk("gcnt0_l1", gc0_a, gcnt_m[0]);     chk("gcnt1_l1", gc1_a, gcnt_m[1]);
      chk("gcnt0_l3", gc0_b, gcnt_m[0]);     chk("gcnt1_l3", gc1_b, gcnt_m[1]);
      if (g >= 0) begin
        e.src   = g;
        e.tag   = (g == 0) ? int'(tag0) : int'(tag1);
        e.data  = ea + 'h100;
        e.issue = cyc;
        q1.push_back(e);
        q3.push_back(e);
        rr_m    = 1 - g;
        owner_m = ((g == 0) ? lock0 : lock1) ? g : -1;
      end else begin
        owner_m = -1;
      end
      if (stat_clr) gcnt_m = '{0, 0};
      else if (g >= 0 && gcnt_m[g] < 'hFFFF) gcnt_m[g]++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor, LUT_LAT=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rsp_excl_l1", int'(rv0_a && rv1_a), 0);
      if (rv0_a || rv1_a) begin
        chk("rsp_pending_l1", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("rsp_src_l1", int'(rv1_a), e.src);
          chk("rsp_tag_l1", rtag_a, e.tag);
          chk("rsp_data_l1", rdata_a, e.data);
          chk("rsp_lat_l1", cyc - e.issue, 1);
        end
      end
      if (q1.size() > 0 && cyc > q1[0].issue + 1) begin
        chk("rsp_lost_l1", cyc - q1[0].issue, 1);
        void'(q1.pop_front());
      end
    end
  end

  // Monitor, LUT_LAT=3 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("rsp_excl_l3", int'(rv0_b && rv1_b), 0);
      if (rv0_b || rv1_b) begin
        chk("rsp_pending_l3", int'(q3.size() > 0), 1);
        if (q3.size() > 0) begin
          e = q3.pop_front();
          chk("rsp_src_l3", int'(rv1_b), e.src);
          chk("rsp_tag_l3", rtag_b, e.tag);
          chk("rsp_data_l3", rdata_b, e.data);
          chk("rsp_lat_l3", cyc - e.issue, 3);
        end
      end
      if (q3.size() > 0 && cyc > q3[0].issue + 3) begin
        chk("rsp_lost_l3", cyc - q3[0].issue, 3);
        void'(q3.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    int g;
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; stat_clr = 0;
    for (int i = 0; i < n; i++) step(g);
  endtask

  initial begin
    int g, n0, n1;
    bit keep0, keep1;

    step(g); step(g);
    reset = 0;
    // Registered outputs straight out of reset.
    chk("rst_rv", int'({rv0_a, rv1_a, rv0_b, rv1_b}), 0);
    chk("rst_data", rdata_a, 0);  chk("rst_tag", rtag_a, 0);
    chk("rst_en", en_a, 0);       chk("rst_addr", la_a, 0);  chk("rst_mux", mux_a, 0);
    chk("rst_infl", infl_b, 0);   chk("rst_gcnt0", gc0_a, 0);

    // Both requesting, no lock: grants should alternate starting with 0.
    n0 = 0; n1 = 0;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 6; i++) begin
      addr0 = 8'(8'h40 + n0); tag0 = 4'(n0);
      addr1 = 8'(8'h80 + n1); tag1 = 4'(n1 + 8);
      step(g);
      chk("alt_grant", g, i % 2);
      if (g == 0) n0++; else if (g == 1) n1++;
    end
    idle(4);
    chk("alt_gcnt0", gc0_a, 3);  chk("alt_gcnt1", gc1_b, 3);
    stat_clr = 1; step(g); stat_clr = 0;

    // Single requester streaming.
    req0 = 1;
    for (int i = 0; i < 20; i++) begin
      addr0 = 8'(i); tag0 = 4'(i);
      step(g);
    end
    idle(4);
    chk("stream_gcnt0", gc0_a, 20);

    // Burst lock on requester 1 while requester 0 waits.
    req0 = 1; addr0 = 8'h33; tag0 = 4'h3;
    req1 = 1; lock1 = 1;
    for (int i = 0; i < 4; i++) begin
      addr1 = 8'(8'hC0 + i); tag1 = 4'(i);
      step(g);
      chk("lock_grant", g, 1);
    end
    req1 = 0; lock1 = 0;
    step(g);
    chk("lock_release", g, 0);
    idle(4);

    // Randomized traffic obeying the hold-while-waiting rule.
    keep0 = 0; keep1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!keep0) begin addr0 = 8'($urandom); tag0 = 4'($urandom); end
      if (!keep1) begin addr1 = 8'($urandom); tag1 = 4'($urandom); end
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      lock0 = 1'($urandom_range(0, 1));
      lock1 = 1'($urandom_range(0, 1));
      stat_clr = ($urandom_range(0, 31) == 0);
      step(g);
      keep0 = req0 && (g != 0);
      keep1 = req1 && (g != 1);
    end
    idle(5);

    // Reset with a lookup being issued: nothing may come back.
    req0 = 1; addr0 = 8'h05; tag0 = 4'h5; reset = 1;
    step(g);
    reset = 0; req0 = 0;
    idle(5);
    chk("rst_mid_gcnt0", gc0_a, 0);

    // Counter saturation, then clear against a concurrent grant.
    req0 = 1;
    for (int i = 0; i < 65537; i++) begin
      addr0 = 8'(i); tag0 = 4'(i);
      step(g);
    end
    chk("sat_gcnt0_l1", gc0_a, 'hFFFF);
    chk("sat_gcnt0_l3", gc0_b, 'hFFFF);
    stat_clr = 1; addr0 = 8'h11;
    step(g);
    stat_clr = 0; req0 = 0;
    chk("clr_gcnt0", gc0_a, 0);
    idle(6);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
